// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   - lsu_state_e : controller state encoding
//   - SZ_*        : access size codes carried on the size port
//   - lsu_req_t   : latched request payload
//   - is_word / is_misaligned : size and alignment helpers
package lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Size code 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (sz == SZ_HALF) mis = lane[0];
    else if (is_word(sz)) mis = (lane != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   word       : word read from memory
//   wdata      : right-justified store data
//   lane       : byte address bits [1:0]
//   size       : access size (SZ_BYTE / SZ_HALF / word)
//   sign_ext   : extend sub-word loads with the sign bit
//   load_c     : selected lane shifted to bit 0 and extended
//   store_c    : word with the selected lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_c,
  output logic [DATA_W-1:0] store_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Load extraction: halfwords use lane[1] only, words ignore the lane.
  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    load_c = word;
    case (size)
      SZ_BYTE: load_c = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: load_c = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_c = word;
    endcase
  end

  // Store merge: untouched lanes keep the value just read from memory.
  always_comb begin
    store_c = word;
    case (size)
      SZ_BYTE: store_c[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) store_c[31:16] = wdata[15:0];
        else         store_c[15:0]  = wdata[15:0];
      end
      default: store_c = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the execute/memory stage and a
// word-wide data memory. Sub-word stores are done as read-modify-write.
//   clk, rst            : clock, asynchronous active-high reset
//   req/we/size/sign_ext/addr/wdata : request, sampled in IDLE only
//   busy, done, rdata, misaligned   : status and load result
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata : data memory port
// Optional: define LSU_MISALIGN_CHECK_EN to complete misaligned halfword/word
// requests immediately with misaligned=1 and no memory access.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] store_c;
  logic        mis_c;

  // The word read in READ is consumed at the READ exit edge, so the extracted
  // load value and merged store word are registered straight from mem_rdata.
  lsu_lane_align u_align (
    .word     (mem_rdata),
    .wdata    (req_q.wdata),
    .lane     (req_q.addr[1:0]),
    .size     (req_q.size),
    .sign_ext (req_q.sign_ext),
    .load_c   (load_c),
    .store_c  (store_c)
  );

  assign mem_addr = {req_q.addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned_q;
  assign mis_c      = is_misaligned(size, addr[1:0]);
  assign misaligned = misaligned_q;
`else
  assign mis_c      = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Controller FSM; all memory and status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      case (state)
        S_IDLE: begin
          if (req) begin
            req_q <= '{we: we, size: size, sign_ext: sign_ext, addr: addr, wdata: wdata};
            busy  <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
            misaligned_q <= mis_c;
`endif
            if (mis_c) begin
              state <= S_DONE;
              done  <= 1'b1;
              rdata <= '0;
            end else if (!we || !is_word(size)) begin
              state    <= S_READ;
              mem_read <= 1'b1;
            end else begin
              state     <= S_WRITE;
              mem_write <= 1'b1;
              mem_wdata <= wdata;
            end
          end
        end
        S_READ: begin
          if (req_q.we) begin
            state     <= S_WRITE;
            mem_write <= 1'b1;
            mem_wdata <= store_c;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
            rdata <= load_c;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
